ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/ram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the RAM port arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TIMEOUT   = 256;

  // Width of a core index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first request found searching upward from last_owner+1.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter int N = DEF_NUM_CORES,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  winner,
  output logic          found
);

  always_comb begin
    logic [IW-1:0] idx;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    // Offset N wraps back to last_owner itself, so it is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_owner) + k) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_CORES cores.
// Define ARB_TIMEOUT_EN to revoke grants held for TIMEOUT cycles.
module ram_port_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES-1:0]             core_valid,
  input  logic [NUM_CORES-1:0]             core_we,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]             core_gnt,
  output logic [DATA_W-1:0]                core_rdata,
  output logic [NUM_CORES-1:0]             core_rvalid,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [DATA_W-1:0]                ram_wdata,
  input  logic [DATA_W-1:0]                ram_rdata,
  output logic                             timeout_err
);

  localparam int IW = idx_w(NUM_CORES);

  arb_state_e           state_q;
  logic [NUM_CORES-1:0] gnt_q;
  logic [NUM_CORES-1:0] rvalid_q;
  logic [IW-1:0]        last_owner_q;

  logic [NUM_CORES-1:0] pick_req;
  logic [NUM_CORES-1:0] pick_gnt;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 owner_req;
  logic                 revoke;

  assign owner_req = |(gnt_q & core_req);

  rr_priority_picker #(
    .N(NUM_CORES)
  ) u_picker (
    .req        (pick_req),
    .last_owner (last_owner_q),
    .winner     (pick_gnt),
    .found      (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (pick_gnt[k]) pick_idx = IW'(k);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]        hold_q, hold_d;
  logic [NUM_CORES-1:0] blk_q, blk_d;
  logic                 timeout_err_q;

  // hold_q counts completed edges under the current grant.
  assign revoke   = (state_q == BUSY) && owner_req && (hold_q == CW'(TIMEOUT - 1));
  assign pick_req = core_req & ~blk_q & ~(gnt_q & {NUM_CORES{revoke}});

  always_comb begin
    hold_d = '0;
    if ((state_q == BUSY) && owner_req && !revoke) hold_d = hold_q + 1'b1;
    // A revoked core stays barred until it lets go of its request.
    blk_d = (blk_q | (gnt_q & {NUM_CORES{revoke}})) & core_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q        <= '0;
      blk_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      blk_q         <= blk_d;
      timeout_err_q <= revoke;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign revoke      = 1'b0;
  assign pick_req    = core_req;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      last_owner_q <= IW'(NUM_CORES - 1);
    end else begin
      // Read return follows the requester even if the grant moves now.
      rvalid_q <= (ram_en && !ram_we) ? gnt_q : '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q      <= BUSY;
            gnt_q        <= pick_gnt;
            last_owner_q <= pick_idx;
          end
        end
        BUSY: begin
          if (!owner_req || revoke) begin
            if (pick_found) begin
              gnt_q        <= pick_gnt;
              last_owner_q <= pick_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // One-hot AND-OR mux; an all-zero grant drives the RAM port to zero.
  logic [NUM_CORES-1:0]             en_terms;
  logic [NUM_CORES-1:0]             we_terms;
  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_terms;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_terms;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_mux
    assign en_terms[gi]    = gnt_q[gi] & core_valid[gi];
    assign we_terms[gi]    = gnt_q[gi] & core_we[gi];
    assign addr_terms[gi]  = gnt_q[gi] ? core_addr[gi]  : '0;
    assign wdata_terms[gi] = gnt_q[gi] ? core_wdata[gi] : '0;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      ram_addr  = ram_addr  | addr_terms[k];
      ram_wdata = ram_wdata | wdata_terms[k];
    end
  end

  assign ram_en      = |en_terms;
  assign ram_we      = |we_terms;
  assign core_gnt    = gnt_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter with a behavioural model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         core_req, core_valid, core_we;
  logic [N-1:0][AW-1:0] core_addr;
  logic [N-1:0][DW-1:0] core_wdata;
  logic [N-1:0]         core_gnt, core_rvalid;
  logic [DW-1:0]        core_rdata, ram_rdata, ram_wdata;
  logic [AW-1:0]        ram_addr;
  logic                 ram_en, ram_we, timeout_err;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_valid(core_valid), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .timeout_err(timeout_err)
  );

  // Simple synchronous RAM with one-cycle read latency.
  logic [DW-1:0] mem [256];
  logic          clr_mem = 1'b1;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  // Behavioural model state: owner index (-1 = none), rotation pointer, etc.
  int            m_owner, m_last, m_hold, m_rv;
  logic [N-1:0]  m_blk;
  logic          m_terr;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i] === 1'b1) begin r = i; c++; end
    end
    return (c == 1) ? r : -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_hold = 0; m_rv = -1; m_blk = '0; m_terr = 1'b0;
  endtask

  task automatic grant_next(input logic [N-1:0] elig);
    m_owner = rr_pick(elig, m_last);
    if (m_owner >= 0) m_last = m_owner;
    m_hold = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    m_rv = -1;
    m_terr = 1'b0;
    if (m_owner >= 0 && core_valid[m_owner]) begin
      if (core_we[m_owner]) m_mem[core_addr[m_owner][7:0]] = core_wdata[m_owner];
      else begin
        m_rv = m_owner;
        m_rd = m_mem[core_addr[m_owner][7:0]];
      end
    end
    elig = core_req & ~m_blk;
    if (m_owner < 0 || !core_req[m_owner]) begin
      grant_next(elig);
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_hold++;
      if (m_hold == TO) begin
        m_blk[m_owner] = 1'b1;
        elig[m_owner]  = 1'b0;
        m_terr         = 1'b1;
        grant_next(elig);
      end
`endif
    end
    m_blk = m_blk & core_req;
  endtask

  task automatic compare_all();
    logic [N-1:0]  eg, erv;
    logic          een, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    eg = '0; erv = '0; een = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      een = core_valid[m_owner];
      ewe = core_we[m_owner];
      ea  = core_addr[m_owner];
      ed  = core_wdata[m_owner];
    end
    if (m_rv >= 0) erv[m_rv] = 1'b1;
    check("gnt", core_gnt, eg);
    check("ram_en", ram_en, een);
    check("ram_we", ram_we, ewe);
    check("ram_addr", ram_addr, ea);
    check("ram_wdata", ram_wdata, ed);
    check("rvalid", core_rvalid, erv);
    check("timeout_err", timeout_err, m_terr);
    if (m_rv >= 0) check("rdata", core_rdata, m_rd);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    core_req = '0; core_valid = '0; core_we = '0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int prev, cnt, gap, idx, seen, gcyc, terrs;

    clear_inputs();
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", core_gnt, 4'b0000);
    check("rst_rvalid", core_rvalid, 4'b0000);
    check("rst_terr", timeout_err, 1'b0);
    step();
    clr_mem = 1'b0;

    // Single requester right after reset release.
    rst_n = 1'b1;
    core_req = 4'b0010;
    core_addr[1] = 32'h40;
    step();
    check("s1_gnt", core_gnt, 4'b0010);
    check("s1_addr", ram_addr, 32'h40);
    core_addr[1] = 32'h44;
    step();
    check("s1_addr_track", ram_addr, 32'h44);
    $display("scenario single_req: gnt=%b addr=0x%0h", core_gnt, ram_addr);

    // All cores requesting, each owner releases after three cycles.
    do_reset();
    prev = -1; cnt = 0; gap = 0; seen = -1;
    for (int c = 0; c < 16; c++) begin
      core_req = 4'b1111;
      if (m_owner >= 0 && cnt == 3) core_req[m_owner] = 1'b0;
      step();
      idx = oh_idx(core_gnt);
      if (idx >= 0 && idx != seen) begin order.push_back(idx); seen = idx; end
      if (core_gnt == '0 && order.size() > 0) gap++;
      if (m_owner == prev) cnt++;
      else cnt = 1;
      prev = m_owner;
    end
    check("s2_grants", order.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) check($sformatf("s2_order%0d", k), order[k], exp_order[k]);
    end
    check("s2_no_gap", gap, 0);
    $display("scenario rotation: %0d grants observed, gaps=%0d", order.size(), gap);

    // Core 2 writes then reads back 0xDEADBEEF at 0x10.
    do_reset();
    core_req = 4'b0100;
    step();
    core_valid[2] = 1'b1; core_we[2] = 1'b1; core_addr[2] = 32'h10; core_wdata[2] = 32'hDEADBEEF;
    step();
    core_we[2] = 1'b0;
    step();
    core_valid[2] = 1'b0;
    check("s3_rvalid", core_rvalid, 4'b0100);
    check("s3_rdata", core_rdata, 32'hDEADBEEF);
    step();
    $display("scenario read: rdata=0x%0h", m_rd);

    // Non-owner write attempt must never reach the RAM.
    do_reset();
    core_req = 4'b1000;
    step();
    core_req = 4'b1001;
    core_valid[0] = 1'b1; core_we[0] = 1'b1; core_addr[0] = 32'h20; core_wdata[0] = 32'h55;
    #1;
    check("s4_we", ram_we, 1'b0);
    check("s4_en", ram_en, 1'b0);
    for (int c = 0; c < 3; c++) step();
    check("s4_ram_untouched", mem[32], 32'h0);
    $display("scenario blocked_write: mem[0x20]=0x%0h", mem[32]);

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    core_req = 4'b0001;
    step();
    core_valid[0] = 1'b1; core_addr[0] = 32'h5;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("s5_gnt_async", core_gnt, 4'b0000);
    check("s5_en_async", ram_en, 1'b0);
    @(negedge clk);
    core_req = 4'b1001; core_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    check("s5_first_gnt", core_gnt, 4'b0001);
    $display("scenario async_reset: gnt after release=%b", core_gnt);

    // Core 1 holds its request for 20 cycles.
    do_reset();
    core_req = 4'b0010;
    gcyc = 0; terrs = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (core_gnt[1] === 1'b1) gcyc++;
      if (timeout_err === 1'b1) terrs++;
    end
`ifdef ARB_TIMEOUT_EN
    check("s6_held", gcyc, TO);
    check("s6_terr", terrs, 1);
    check("s6_not_regranted", core_gnt, 4'b0000);
`else
    check("s6_held", gcyc, 20);
    check("s6_terr", terrs, 0);
`endif
    core_req = 4'b0000;
    step();
    core_req = 4'b0010;
    step();
    check("s6_regrant", core_gnt, 4'b0010);
    $display("scenario hold: granted %0d cycles, timeout pulses %0d", gcyc, terrs);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) core_req[i] = ~core_req[i];
        core_valid[i] = 1'($urandom_range(0, 1));
        core_we[i]    = 1'($urandom_range(0, 1));
        core_addr[i]  = AW'($urandom_range(0, 255));
        core_wdata[i] = $urandom;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    clear_inputs();
    step();
    step();
    for (int i = 0; i < 256; i++) check($sformatf("mem[%0d]", i), mem[i], m_mem[i]);
    $display("scenario random: 3000 cycles of traffic");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
